// File: rtl/csa_resolve_cpa.sv
// Resolves a redundant (sum, carry, carry-out) triple into one binary result:
// a 3:2 compression at accept, then a CHUNK-bit ripple add per cycle.
module csa_resolve_cpa #(
    parameter int width = 64,
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width-1:0]   s_in,
    input  logic [width-1:0]   c_in,
    input  logic [width-1:0]   co_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width+2:0]   result,
    output logic               res_zero
);
    localparam int RW  = width + 3;
    localparam int NCH = (RW + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CU = CHUNK;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            cy;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [RW-1:0]   res_q;

    logic [PW-1:0]   s_x, c_x, co_x, a_d, b_d;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]  sum;
    logic [RW-1:0]   res_d;
    int unsigned     k_u;

    always_comb begin
        s_x  = PW'(s_in);
        c_x  = PW'(c_in) << 1;
        co_x = PW'(co_in) << 1;
        a_d  = s_x ^ c_x ^ co_x;
        b_d  = ((s_x & c_x) | (s_x & co_x) | (c_x & co_x)) << 1;

        k_u     = 32'(k);
        a_chunk = CHUNK'(a_q >> (CU * k_u));
        b_chunk = CHUNK'(b_q >> (CU * k_u));
        sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(cy);

        // Only the bits of chunk k are replaced; bits past RW-1 are dropped.
        res_d = res_q;
        for (int unsigned i = 0; i < RW; i++) begin
            if ((i / CU) == k_u)
                res_d[i] = sum[i % CU];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            cy        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            out_valid <= 1'b0;
            res_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        k     <= '0;
                        cy    <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    res_q <= res_d;
                    cy    <= sum[CHUNK];
                    if (k == KW'(NCH - 1)) begin
                        k         <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res_zero  <= (res_d == '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        res_zero  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign result   = res_q;
endmodule
